// File: rtl/serial_mant_inc_ctrl.sv
// Bit-serial mantissa incrementer: one half-adder cell walks LSB->MSB and stops once the carry dies.
// Start/done handshake; oResult/oOvf update only on completion.
`timescale 1ns/1ps
module serial_mant_inc_ctrl #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 6
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iInc,
  input  logic [WIDTH-1:0] iMant,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult,
  output logic             oOvf
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_work, w_work_next;
  logic             r_carry, w_carry_next;
  logic [CNT_W-1:0] r_idx, w_idx_next;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_mask;
  logic             w_bit;
  logic             w_cout;
  logic             w_last;

  // Half-adder cell on bit r_idx: sum goes back via an XOR mask, carry is bit AND carry.
  assign w_shifted = r_work >> r_idx;
  assign w_bit     = w_shifted[0];
  assign w_cout    = w_bit & r_carry;
  assign w_mask    = {{(WIDTH-1){1'b0}}, r_carry} << r_idx;
  assign w_last    = (r_idx == CNT_W'(WIDTH-1));

  always_comb begin
    w_state_next = r_state;
    w_work_next  = r_work;
    w_carry_next = r_carry;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_work_next  = iMant;
          w_carry_next = iInc;
          w_idx_next   = '0;
          w_state_next = iInc ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        w_work_next  = r_work ^ w_mask;
        w_carry_next = w_cout;
        w_idx_next   = r_idx + CNT_W'(1);
        if (!w_cout || w_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oResult <= '0;
      oOvf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_work  <= w_work_next;
      r_carry <= w_carry_next;
      r_idx   <= w_idx_next;
      oBusy   <= (w_state_next == S_SHIFT);
      oDone   <= (w_state_next == S_DONE);
      // Publish only on DONE entry so SHIFT never leaks partial work values.
      if (w_state_next == S_DONE) begin
        oResult <= w_work_next;
        oOvf    <= w_carry_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_mant_inc_ctrl.sv
// Directed bench for serial_mant_inc_ctrl with hand-computed results and latencies.
`timescale 1ns/1ps
module tb_serial_mant_inc_ctrl;
  localparam int WIDTH = 24;

  logic             iClk = 1'b0;
  logic             iRst = 1'b1;
  logic             iStart = 1'b0;
  logic             iInc = 1'b0;
  logic [WIDTH-1:0] iMant = '0;
  logic             oBusy, oDone, oOvf;
  logic [WIDTH-1:0] oResult;

  int total = 0;
  int bad = 0;

  serial_mant_inc_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iInc(iInc), .iMant(iMant),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult), .oOvf(oOvf)
  );

  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one start, track busy cycles and done timing; optional stray start at SHIFT cycle intr.
  task automatic run_op(input string name, input logic [WIDTH-1:0] mant, input logic inc,
                        input logic [WIDTH-1:0] exp_res, input logic exp_ovf,
                        input int exp_p, input int intr);
    logic [WIDTH-1:0] prev_res;
    int busy_cnt;
    int done_at;
    @(negedge iClk);
    prev_res = oResult;
    iStart = 1'b1; iMant = mant; iInc = inc;
    @(posedge iClk);
    #1 iStart = 1'b0;
    busy_cnt = 0;
    done_at  = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge iClk);
      if (intr != 0 && n == intr + 1) iStart = 1'b0;
      check_eq({name, " busy_done_excl"}, 64'(oBusy & oDone), 64'd0);
      if (oDone) begin
        done_at = n;
        break;
      end
      if (oBusy) begin
        busy_cnt++;
        check_eq({name, " result_hold_shift"}, 64'(oResult), 64'(prev_res));
      end
      if (intr != 0 && n == intr) begin
        iStart = 1'b1; iMant = '0;
      end
    end
    iStart = 1'b0;
    check_eq({name, " done_latency"}, 64'(done_at), 64'(exp_p + 1));
    check_eq({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_p));
    check_eq({name, " result"}, 64'(oResult), 64'(exp_res));
    check_eq({name, " ovf"}, 64'(oOvf), 64'(exp_ovf));
    @(negedge iClk);
    check_eq({name, " done_one_cycle"}, 64'(oDone), 64'd0);
    check_eq({name, " idle_not_busy"}, 64'(oBusy), 64'd0);
    check_eq({name, " result_hold_idle"}, 64'(oResult), 64'(exp_res));
    $display("op %s: mant=0x%06h inc=%0d -> result=0x%06h ovf=%0d latency=%0d",
             name, mant, inc, oResult, oOvf, done_at);
  endtask

  initial begin
    int dones;
    int last_done;
    #1;
    check_eq("reset_busy", 64'(oBusy), 64'd0);
    check_eq("reset_done", 64'(oDone), 64'd0);
    check_eq("reset_result", 64'(oResult), 64'd0);
    check_eq("reset_ovf", 64'(oOvf), 64'd0);
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;

    run_op("simple", 24'h000000, 1'b1, 24'h000001, 1'b0, 1, 0);
    run_op("chain", 24'h00000F, 1'b1, 24'h000010, 1'b0, 5, 0);
    run_op("wrap", 24'hFFFFFF, 1'b1, 24'h000000, 1'b1, 24, 0);

    // Reset asserted asynchronously during SHIFT cycle 3 of an all-ones op.
    @(negedge iClk);
    iStart = 1'b1; iMant = 24'hFFFFFF; iInc = 1'b1;
    @(posedge iClk);
    #1 iStart = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    @(negedge iClk);
    check_eq("midrst_busy_before", 64'(oBusy), 64'd1);
    #2 iRst = 1'b1;
    #1;
    check_eq("midrst_busy_async", 64'(oBusy), 64'd0);
    check_eq("midrst_result", 64'(oResult), 64'd0);
    check_eq("midrst_ovf", 64'(oOvf), 64'd0);
    @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge iClk);
      if (oDone || oBusy) dones++;
    end
    check_eq("midrst_no_done", 64'(dones), 64'd0);
    $display("op midrst: reset during shift, activity after reset=%0d", dones);
    run_op("after_rst", 24'h000001, 1'b1, 24'h000002, 1'b0, 2, 0);

    run_op("pass", 24'hABCDEF, 1'b0, 24'hABCDEF, 1'b0, 0, 0);
    run_op("ignored_start", 24'h7FFFFF, 1'b1, 24'h800000, 1'b0, 24, 4);

    // Held start: completions every 4 cycles (2 SHIFT + DONE + IDLE).
    @(negedge iClk);
    iStart = 1'b1; iMant = 24'h000001; iInc = 1'b1;
    dones = 0;
    last_done = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge iClk);
      if (oDone) begin
        check_eq("b2b_result", 64'(oResult), 64'h2);
        if (last_done >= 0) check_eq("b2b_spacing", 64'(n - last_done), 64'd4);
        $display("op b2b: done at cycle %0d result=0x%06h", n, oResult);
        last_done = n;
        dones++;
      end
    end
    check_eq("b2b_count", 64'(dones >= 6), 64'd1);
    iStart = 1'b0;
    repeat (10) @(negedge iClk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_mant_inc_ctrl.md
Name: serial_mant_inc_ctrl

Overview:
Controller that sequences a single one-bit half-adder cell (sum = a XOR b, carry = a AND b) to perform mantissa round-up (+1) for the FP normalization path. It processes one bit per cycle, LSB first, and exits early once the carry dies. A start/done handshake makes it an area-cheap replacement for a WIDTH-bit incrementer in the round stage.

Parameters:
WIDTH, 24, mantissa width in bits (including hidden bit); legal range 2..64
CNT_W, 6, bit-index counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
iClk  input  1  clock, rising-edge active
iRst  input  1  asynchronous, active-high reset
iStart  input  1  start request; sampled only in IDLE
iInc  input  1  1 = add one to operand, 0 = pass operand through unchanged
iMant  input  WIDTH  operand, captured on the accepted start edge
oBusy  output  1  high while in SHIFT
oDone  output  1  single-cycle completion pulse
oResult  output  WIDTH  incremented or passed-through mantissa
oOvf  output  1  carry out of the MSB (mantissa wrapped to zero)

Behaviour:
- One clock: iClk. Reset is asynchronous and active-high (iRst).
- Reset (any time, including mid-operation):
  - state -> IDLE
  - oBusy = 0, oDone = 0, oResult = 0, oOvf = 0
  - internal work register, carry and index cleared
  - an in-flight operation is discarded with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - iStart=1 at edge E0: capture iMant into work register, carry <= iInc, index <= 0.
  - If iInc=1, go to SHIFT.
  - If iInc=0, go directly to DONE.
- SHIFT, one bit per edge, at index k:
  - w[k] <= w[k] XOR c; c <= w[k] AND c; index <= k+1.
  - Go to DONE when the new carry is 0 or when k = WIDTH-1; otherwise stay in SHIFT.
  - Higher bits are untouched on early exit, because carry 0 leaves them unchanged.
- Entering DONE:
  - oResult <= final work value.
  - oOvf <= final carry; this is 1 only when all WIDTH bits were processed and carry remained 1.
- DONE: oDone = 1 for exactly one cycle, then unconditional return to IDLE.
- Latency:
  - Let P = bits processed: P = 0 if iInc=0; otherwise P = min(t+1, WIDTH), where t = number of trailing ones in iMant.
  - DONE is entered at edge E0+P.
  - oDone is high for the cycle between E0+P and E0+P+1.
  - Minimum: P=0 (pass-through). Maximum: P=WIDTH (all ones).
- Start handling:
  - iStart while in SHIFT or DONE is ignored and not queued.
  - iStart held high continuously re-arms on the first IDLE cycle, so back-to-back ops are spaced by one IDLE cycle.
- Output stability:
  - oResult and oOvf change only on entry to DONE (or on reset).
  - Both hold their values through IDLE until the next completion.
  - oResult must not expose intermediate work-register values during SHIFT.
- oBusy = 1 exactly when state = SHIFT.
- oBusy and oDone are registered and never high in the same cycle.

Test Plan:
- Reset mid-op: iRst asserted in cycle 3 of an 0xFFFFFF operation -> oBusy=0 immediately (asynchronous), oDone never pulses, oResult=0, oOvf=0; a following start with 0x000001, iInc=1 completes normally with oResult=0x000002.
- Simple increment: iMant=0x000000, iInc=1 -> P=1; oBusy high 1 cycle; oDone high at E0+1; oResult=0x000001, oOvf=0.
- Carry chain: iMant=0x00000F, iInc=1 -> P=5; oBusy high 5 cycles; oResult=0x000010, oOvf=0; verify oResult is unchanged during SHIFT.
- Full wrap: iMant=0xFFFFFF, iInc=1 -> P=24; oResult=0x000000, oOvf=1; oDone exactly one cycle.
- Pass-through and ignored start: iMant=0xABCDEF, iInc=0 -> oDone at E0, oResult=0xABCDEF, oOvf=0. Then start 0x7FFFFF, iInc=1, and pulse iStart with 0x000000 in SHIFT cycle 4 -> ignored; result 0x800000, P=24, oOvf=0.
- Back-to-back: iStart held high with iMant=0x000001, iInc=1 -> ops complete repeatedly; each oDone separated by SHIFT(2)+DONE+IDLE; oResult=0x000002 each time.
